// File: rtl/fetch_pkg.sv
// Shared defaults, the decode-buffer entry type and PC alignment helper for the fetch stage.
package fetch_pkg;

  localparam int                   DEF_XLEN         = 32;
  localparam int                   DEF_INST_BYTES   = 4;
  localparam int                   DEF_QDEPTH       = 4;
  localparam logic [DEF_XLEN-1:0]  DEF_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] inst;
  } fetch_entry_t;

  // Clears the sub-instruction offset bits; works for any XLEN up to 64.
  function automatic logic [63:0] pc_align(input logic [63:0] addr, input int unsigned inst_bytes);
    return addr & ~(64'(inst_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used for the PC tag queue and the decode buffer.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || pop);
  end

  // Storage and pointers; flush discards contents but leaves storage untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Multi-outstanding sequential fetch: credit-limited imem requests, in-order response
// buffering with PC tags, and redirect flush that discards still-unanswered requests.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter int              INST_BYTES   = DEF_INST_BYTES,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int              QDEPTH       = DEF_QDEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_inst,
  output logic [XLEN-1:0] dec_pc
);

  localparam int              CW      = $clog2(QDEPTH+1);
  localparam logic [CW:0]     QD_W    = (CW+1)'(QDEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INST_BYTES);

  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     drop_cnt;
  logic [CW:0]       in_use;
  logic              req_fire;
  logic              rsp_keep;
  logic              dec_fire;
  logic [XLEN-1:0]   tag_head;
  logic [CW-1:0]     tag_count;
  logic              tag_full;
  logic              tag_empty;
  logic [2*XLEN-1:0] buf_head;
  logic [CW-1:0]     buf_count;
  logic              buf_full;
  logic              buf_empty;

  // Credit: every in-flight request has a reserved buffer slot, so responses never stall.
  always_comb begin
    in_use          = {1'b0, outstanding} + {1'b0, buf_count};
    imem_req_valid  = rst_n && (in_use < QD_W) && !redirect_valid;
    req_fire        = imem_req_valid && imem_req_ready;
    rsp_keep        = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    dec_fire        = dec_valid && dec_ready;
    outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  end

  // Fetch PC: redirect target (aligned) wins, otherwise advance on each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_VECTOR;
    end else if (redirect_valid) begin
      fetch_pc <= XLEN'(pc_align(64'(redirect_addr), INST_BYTES));
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  // In-flight and to-be-dropped counts; a redirect marks every unanswered request stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid)
        drop_cnt <= outstanding_nxt;
      else if (imem_rsp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(QDEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .flush     (redirect_valid),
    .head_data (tag_head),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(QDEPTH)) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data ({tag_head, imem_rsp_data}),
    .pop       (dec_fire),
    .flush     (redirect_valid),
    .head_data (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign imem_req_addr = fetch_pc;
  assign dec_valid     = !buf_empty;
  assign dec_pc        = buf_head[2*XLEN-1:XLEN];
  assign dec_inst      = buf_head[XLEN-1:0];

  a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
    int'(outstanding) <= QDEPTH);
  a_tag_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
    tag_count == outstanding - drop_cnt);
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    req_fire |-> !tag_full);
  a_tag_present: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_keep |-> !tag_empty);
  a_buf_has_room: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_keep |-> (!buf_full || dec_fire));

endmodule
